// File: rtl/fetch_irq_unit.sv
// rtl/fetch_irq_unit.sv - instruction fetch stage with PC, IF/ID latch and interrupt entry sequencing
// Optional interrupt support is enabled with `define FETCH_IRQ_EN; without it only RUN exists.
module fetch_irq_unit #(
  parameter logic [31:0] RESET_PC     = 32'd32,
  parameter logic [31:0] INT_PC       = 32'd0,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        rti_done,
  input  logic [31:0] rti_pc,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        int_push,
  output logic [31:0] int_ret_pc,
  output logic        in_isr
);

  localparam logic [15:0] NOP = 16'h0000;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [15:0] instr_next;
  logic [31:0] pc_out_next;
  logic        valid_next;

  assign imem_addr = pc;

`ifdef FETCH_IRQ_EN
  typedef enum logic [1:0] {RUN, DRAIN, PUSH, ISR} state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t      state, state_next;
  logic        pending, pending_next;
  logic [3:0]  count, count_next;
  logic [31:0] ret_pc, ret_pc_next;
  logic        req;

  // a request arriving this cycle is treated as already pending
  assign req        = pending | interrupt;
  assign int_push   = (state == PUSH);
  assign in_isr     = (state == ISR);
  assign int_ret_pc = ret_pc;

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= RESET_PC;
      pending   <= 1'b0;
      count     <= 4'd0;
      ret_pc    <= 32'd0;
      instr_out <= NOP;
      pc_out    <= 32'd0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      pending   <= pending_next;
      count     <= count_next;
      ret_pc    <= ret_pc_next;
      instr_out <= instr_next;
      pc_out    <= pc_out_next;
      valid_out <= valid_next;
    end
  end

  // next-state: redirect beats interrupt entry, which beats stall, which beats advance
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = req;
    count_next   = count;
    ret_pc_next  = ret_pc;
    instr_next   = instr_out;
    pc_out_next  = pc_out;
    valid_next   = valid_out;
    case (state)
      RUN, ISR: begin
        if (state == ISR && rti_done) begin
          pc_next    = rti_pc;
          instr_next = NOP;
          valid_next = 1'b0;
          state_next = RUN;
        end else if (branch_taken) begin
          pc_next    = branch_target;
          instr_next = NOP;
          valid_next = 1'b0;
        end else if (state == RUN && req && !stall) begin
          ret_pc_next  = pc;
          instr_next   = NOP;
          valid_next   = 1'b0;
          count_next   = DRAIN_LAST;
          pending_next = 1'b0;
          state_next   = DRAIN;
        end else if (!stall) begin
          instr_next  = imem_data;
          pc_out_next = pc;
          valid_next  = 1'b1;
          pc_next     = pc + 32'd1;
        end
      end
      DRAIN: begin
        // redirects here belong to the instruction frozen at entry and are dropped
        if (!stall) begin
          instr_next = NOP;
          valid_next = 1'b0;
          if (count == 4'd0) state_next = PUSH;
          else               count_next = count - 4'd1;
        end
      end
      PUSH: begin
        instr_next = NOP;
        valid_next = 1'b0;
        pc_next    = INT_PC;
        state_next = ISR;
      end
      default: state_next = RUN;
    endcase
  end
`else
  logic        unused_irq;
  logic [35:0] unused_cfg;

  assign unused_irq = ^{interrupt, rti_done, rti_pc};
  assign unused_cfg = {INT_PC, 4'(DRAIN_CYCLES)};
  assign int_push   = 1'b0;
  assign int_ret_pc = 32'd0;
  assign in_isr     = 1'b0;

  // PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      instr_out <= NOP;
      pc_out    <= 32'd0;
      valid_out <= 1'b0;
    end else begin
      pc        <= pc_next;
      instr_out <= instr_next;
      pc_out    <= pc_out_next;
      valid_out <= valid_next;
    end
  end

  // redirect beats stall, which beats advance
  always_comb begin
    pc_next     = pc;
    instr_next  = instr_out;
    pc_out_next = pc_out;
    valid_next  = valid_out;
    if (branch_taken) begin
      pc_next    = branch_target;
      instr_next = NOP;
      valid_next = 1'b0;
    end else if (!stall) begin
      instr_next  = imem_data;
      pc_out_next = pc;
      valid_next  = 1'b1;
      pc_next     = pc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_irq_unit.sv
// tb/tb_fetch_irq_unit.sv - directed self-checking bench for fetch_irq_unit
module tb_fetch_irq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        interrupt;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        rti_done;
  logic [31:0] rti_pc;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        int_push;
  logic [31:0] int_ret_pc;
  logic        in_isr;

  int checks = 0;
  int errors = 0;

  fetch_irq_unit #(.RESET_PC(32'd32), .INT_PC(32'd0), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .rti_done(rti_done), .rti_pc(rti_pc), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr_out(instr_out), .pc_out(pc_out),
    .valid_out(valid_out), .int_push(int_push), .int_ret_pc(int_ret_pc),
    .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  // instruction memory model
  function automatic logic [15:0] mem(input logic [31:0] a);
    case (a)
      32'd32:  mem = 16'h411F;
      32'd33:  mem = 16'h4AFF;
      default: mem = {a[7:0] ^ 8'h5A, a[7:0]};
    endcase
  endfunction

  assign imem_data = mem(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one rising edge, end at the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int c;
    int push_at;
    reset = 1'b1; interrupt = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'd0; rti_done = 1'b0; rti_pc = 32'd0;
    step(); step();
    check("rst_pc", imem_addr, 32'd32);
    check("rst_instr", {16'd0, instr_out}, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_push", {31'd0, int_push}, 32'd0);
    check("rst_ret", int_ret_pc, 32'd0);
    check("rst_isr", {31'd0, in_isr}, 32'd0);

    reset = 1'b0;
    step();
    check("f0_instr", {16'd0, instr_out}, 32'h411F);
    check("f0_pc", pc_out, 32'd32);
    check("f0_valid", {31'd0, valid_out}, 32'd1);
    step();
    check("f1_instr", {16'd0, instr_out}, 32'h4AFF);
    check("f1_pc", pc_out, 32'd33);
    step();
    check("f2_pc", pc_out, 32'd34);
    check("f2_addr", imem_addr, 32'd35);

    // branch at pc=35 to 40
    branch_taken = 1'b1; branch_target = 32'd40;
    step();
    branch_taken = 1'b0;
    check("br_bubble", {31'd0, valid_out}, 32'd0);
    check("br_addr", imem_addr, 32'd40);
    step();
    check("br_pc", pc_out, 32'd40);
    check("br_instr", {16'd0, instr_out}, {16'd0, mem(32'd40)});
    check("br_valid", {31'd0, valid_out}, 32'd1);

    // stall holds everything
    stall = 1'b1;
    step(); step();
    check("st_pc_out", pc_out, 32'd40);
    check("st_addr", imem_addr, 32'd41);
    stall = 1'b0;
    step();
    check("st_resume", pc_out, 32'd41);

    // branch during stall still redirects; PC wraps
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFF);
    step();
    check("wr_pc", pc_out, 32'hFFFF_FFFF);
    check("wr_next", imem_addr, 32'd0);

`ifdef FETCH_IRQ_EN
    branch_taken = 1'b1; branch_target = 32'd36;
    step();
    branch_taken = 1'b0;
    // c0: pc=36, one-cycle interrupt pulse
    interrupt = 1'b1;
    step();
    interrupt = 1'b0;
    check("irq_nop", {31'd0, valid_out}, 32'd0);
    check("irq_hold", imem_addr, 32'd36);
    check("irq_c1_push", {31'd0, int_push}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'd99;
    step();
    branch_taken = 1'b0;
    check("drn_br_ign", imem_addr, 32'd36);
    check("irq_c2_push", {31'd0, int_push}, 32'd0);
    step();
    check("irq_c3_push", {31'd0, int_push}, 32'd0);
    step();
    check("irq_c4_push", {31'd0, int_push}, 32'd0);
    step();
    check("irq_c5_push", {31'd0, int_push}, 32'd1);
    check("irq_ret", int_ret_pc, 32'd36);
    check("irq_c5_valid", {31'd0, valid_out}, 32'd0);
    step();
    check("isr_push_off", {31'd0, int_push}, 32'd0);
    check("isr_flag", {31'd0, in_isr}, 32'd1);
    check("isr_vec", imem_addr, 32'd0);
    step();
    check("isr_instr", {16'd0, instr_out}, {16'd0, mem(32'd0)});
    check("isr_pc", pc_out, 32'd0);
    check("isr_valid", {31'd0, valid_out}, 32'd1);

    // second request inside ISR stays pending
    interrupt = 1'b1;
    step();
    interrupt = 1'b0;
    check("isr2_pc", pc_out, 32'd1);
    check("isr2_push", {31'd0, int_push}, 32'd0);
    step();
    check("isr2_flag", {31'd0, in_isr}, 32'd1);
    check("isr2_pc2", pc_out, 32'd2);

    // rti wins over a simultaneous branch
    rti_done = 1'b1; rti_pc = 32'd36; branch_taken = 1'b1; branch_target = 32'd50;
    step();
    rti_done = 1'b0; branch_taken = 1'b0;
    check("rti_isr", {31'd0, in_isr}, 32'd0);
    check("rti_addr", imem_addr, 32'd36);
    check("rti_nop", {31'd0, valid_out}, 32'd0);
    step();
    check("pend_ret", int_ret_pc, 32'd36);
    check("pend_nop", {31'd0, valid_out}, 32'd0);

    // stall 3 cycles mid-drain delays push by 3
    c = 1;
    push_at = -1;
    for (int i = 0; i < 20 && push_at < 0; i++) begin
      stall = (c >= 1 && c <= 3);
      step();
      c++;
      if (int_push) push_at = c;
    end
    stall = 1'b0;
    check("stall_push_cyc", push_at, 32'd8);
    check("stall_ret", int_ret_pc, 32'd36);

    // reset during push aborts
    reset = 1'b1;
    step();
    check("rp_push", {31'd0, int_push}, 32'd0);
    check("rp_isr", {31'd0, in_isr}, 32'd0);
    check("rp_pc", imem_addr, 32'd32);
    check("rp_ret", int_ret_pc, 32'd0);
    reset = 1'b0;
    step();
    check("rp_fetch", {16'd0, instr_out}, 32'h411F);
    check("rp_push2", {31'd0, int_push}, 32'd0);
`else
    interrupt = 1'b1; rti_done = 1'b1; rti_pc = 32'd36;
    step();
    interrupt = 1'b0; rti_done = 1'b0;
    check("noirq_pc", pc_out, 32'd0);
    check("noirq_valid", {31'd0, valid_out}, 32'd1);
    check("noirq_push", {31'd0, int_push}, 32'd0);
    check("noirq_isr", {31'd0, in_isr}, 32'd0);
    check("noirq_addr", imem_addr, 32'd1);
    step(); step(); step(); step(); step();
    check("noirq_pc5", pc_out, 32'd5);
    check("noirq_push5", {31'd0, int_push}, 32'd0);
    check("noirq_ret", int_ret_pc, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_irq_unit.md
# fetch_irq_unit

Instruction-fetch stage of the pipelined processor. It owns the program counter and drives the instruction-memory address. It registers the fetched 16-bit instruction into the IF/ID latch consumed by the decode stage. It also sequences interrupt entry (drain, return-PC hand-off, vector jump) and RTI return redirection.

## Interface
Parameters:
- RESET_PC, 32, PC loaded by reset
- INT_PC, 0, interrupt service routine vector
- DRAIN_CYCLES, 4, NOP bubbles issued before interrupt hand-off (1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- interrupt  in  1  interrupt request; may be a single-cycle pulse
- stall  in  1  hazard stall from decode; freezes PC, IF/ID and drain counter
- branch_taken  in  1  redirect request, one cycle
- branch_target  in  32  redirect PC
- rti_done  in  1  RTI completed downstream (return PC popped), one cycle
- rti_pc  in  32  popped return PC
- imem_addr  out  32  instruction-memory address (combinational read, data same cycle)
- imem_data  in  16  instruction word at imem_addr
- instr_out  out  16  IF/ID instruction
- pc_out  out  32  IF/ID PC of instr_out
- valid_out  out  1  instr_out is a real instruction (0 = injected NOP)
- int_push  out  1  one-cycle strobe: push int_ret_pc onto stack
- int_ret_pc  out  32  return PC captured at interrupt entry
- in_isr  out  1  ISR active, further interrupts held pending

## Operation
- NOP encoding 16'h0000. imem_addr = pc register.
- Reset: pc=RESET_PC, state=RUN, pending=0, instr_out=0, pc_out=0, valid_out=0, int_push=0, int_ret_pc=0, in_isr=0, drain count=0.
- pending: set when interrupt=1; cleared only on entering DRAIN. A request during ISR stays pending until after RTI.
- States and actions (priority: reset > redirect > interrupt entry > stall > advance):
- RUN/ISR, branch_taken or (rti_done in ISR): pc<=target (branch_target; rti_pc for RTI, which wins if both), IF/ID<=NOP, valid_out=0. RTI moves ISR->RUN.
- RUN, pending and no stall/redirect: int_ret_pc<=pc, IF/ID<=NOP, count<=DRAIN_CYCLES-1, pending<=0, ->DRAIN. pc held.
- RUN/ISR, stall: everything held.
- RUN/ISR, otherwise: instr_out<=imem_data, pc_out<=pc, valid_out<=1, pc<=pc+1 (wraps mod 2^32).
- DRAIN: IF/ID<=NOP each non-stalled cycle. Count decrements; at 0 ->PUSH. branch_taken/rti_done here are ignored, because the frozen instruction was already issued before entry.
- PUSH: int_push=1 for one cycle, IF/ID<=NOP, pc<=INT_PC, ->ISR. stall does not extend PUSH.
- ISR: in_isr=1. Fetches as RUN; pending not serviced.
- rti_done outside ISR is ignored.

## Timing
- Fetch latency 1 cycle: imem_addr=P in cycle n gives instr_out=mem[P], pc_out=P after edge n.
- After reset release: first valid instruction (mem[RESET_PC]) on instr_out 1 cycle later.
- Redirect: 1 bubble; target instruction valid 2 edges after the branch_taken edge.
- Interrupt: request edge to int_push = DRAIN_CYCLES+1 cycles (no stall). First ISR instruction on instr_out the edge after PUSH.
- Reset mid-DRAIN/PUSH/ISR: abort; pending and int_ret_pc cleared.

## Configuration
- FETCH_IRQ_EN defined: interrupt logic as above.
- Undefined: interrupt ignored; DRAIN/PUSH/ISR removed. int_push, int_ret_pc and in_isr tied 0; rti_done ignored. Only RUN exists.

## Test plan
- Reset, mem[32]=16'h411F, mem[33]=16'h4AFF -> instr_out 16'h411F/pc_out 32, then 16'h4AFF/33, valid_out=1.
- branch_taken with target 40 at pc=35 -> one NOP (valid_out=0), then pc_out=40.
- 1-cycle interrupt pulse at pc=36, DRAIN_CYCLES=4 -> 4 NOPs, int_push=1 with int_ret_pc=36, then instr_out=mem[0], in_isr=1.
- Second interrupt during ISR, then rti_done with rti_pc=36 -> fetch resumes at 36. Pending is serviced next: int_ret_pc = the then-current pc.
- stall held 3 cycles mid-DRAIN -> drain count frozen, int_push delayed by exactly 3 cycles.
- reset asserted during PUSH -> pc=32, in_isr=0, int_push=0 next cycle.
